uart_rx_param: RTL and testbench

Parametrised UART receive engine, the next generation of the fixed 8-bit, even-parity receiver. Recovers serial frames from `rx_in` with configurable bit period, data width, parity mode and stop-bit count. Uses mid-bit sampling with false-start rejection and reports parity and framing errors per frame. Sits between the board pin and the host-side byte consumer, delivering each frame as a one-cycle valid pulse.

---
 rtl/uart_rx_param.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling FSM
// with false-start rejection, optional even/odd parity, 1 or 2 stop bits.
// Latency: rx_valid pulses the cycle after the final stop-bit sample.
// There is no backpressure: the consumer must capture outputs on rx_valid.
//
// Ports:
//   clock        - single clock for all logic
//   reset_n      - asynchronous active-low reset
//   rx_in        - asynchronous serial line, idles high
//   rx_data      - last received data word, bit 0 = first bit on the line
//   rx_valid     - one-cycle pulse per completed frame (errored frames too)
//   parity_error - parity flag of the last frame (0 when parity disabled)
//   frame_error  - a stop bit of the last frame was sampled low
//   busy         - FSM is outside IDLE
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy
);

  // Elaboration-time rejection of unsupported parameter values.
  if (CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  // Index of the last stop bit: 0 for one stop bit, 1 for two.
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser. Both flops reset high so a reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath state
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;        // parity flag of frame in flight
  logic                 ferr_q, ferr_d;        // framing flag of frame in flight
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 frame_error_q, frame_error_d;

  logic                 bit_end;
  logic                 exp_par;
  logic                 fe_now;

  assign bit_end = (cnt_q == CNT_LAST);
  // Expected parity bit: even mode sends XOR of data, odd mode its inverse.
  assign exp_par = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    stop_idx_d     = stop_idx_q;
    shift_d        = shift_q;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    fe_now         = ferr_q | ~rx_s_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_s_q) begin
            // Genuine start bit at its midpoint: arm a fresh frame.
            state_d    = S_DATA;
            cnt_d      = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            shift_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end else begin
            // Line went back high before mid-start: a glitch, drop silently.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ exp_par;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          ferr_d = fe_now;
          if (stop_idx_q == STOP_LAST) begin
            // Final stop sample: publish the frame, errored or not.
            rx_data_d      = shift_q;
            parity_error_d = perr_q;
            frame_error_d  = fe_now;
            rx_valid_d     = 1'b1;
            // A low stop means a break or stuck line; wait for it to release
            // so the low level is not mistaken for the next start bit.
            state_d        = fe_now ? S_BRK_WAIT : S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BRK_WAIT: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      stop_idx_q     <= 1'b0;
      shift_q        <= '0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      stop_idx_q     <= stop_idx_d;
      shift_q        <= shift_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three instances (8E1, 8O1, 7N2, 16 clk/bit)
// driven by a frame generator that pushes expected words to per-instance
// queues; monitors pop and compare on every rx_valid pulse.
`timescale 1ns/100ps
module tb_uart_rx_param;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clock;
  logic reset_n;
  logic rx_a, rx_b, rx_c;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc     = 0;
  int unsigned va_last = 0;
  int unsigned va_prev = 0;

  // Clock edges sit on half-nanosecond times; stimulus uses whole-ns delays
  // only, so line changes never coincide with a sampling edge.
  initial begin
    clock = 1'b0;
    #0.5;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .parity_error(perr_a), .frame_error(ferr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .parity_error(perr_b), .frame_error(ferr_b), .busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .rx_in(rx_c), .rx_data(data_c), .rx_valid(valid_c),
    .parity_error(perr_c), .frame_error(ferr_c), .busy(busy_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: every rx_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid_a === 1'b1) begin
      va_prev = va_last;
      va_last = cyc;
      check_eq("a_valid_expected", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        check_eq("a_data", 32'(data_a), 32'(e_a.data));
        check_eq("a_perr", 32'(perr_a), 32'(e_a.perr));
        check_eq("a_ferr", 32'(ferr_a), 32'(e_a.ferr));
      end
    end
  end

  always @(negedge clock) begin
    if (valid_b === 1'b1) begin
      check_eq("b_valid_expected", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        check_eq("b_data", 32'(data_b), 32'(e_b.data));
        check_eq("b_perr", 32'(perr_b), 32'(e_b.perr));
        check_eq("b_ferr", 32'(ferr_b), 32'(e_b.ferr));
      end
    end
  end

  always @(negedge clock) begin
    if (valid_c === 1'b1) begin
      check_eq("c_valid_expected", 32'(q_c.size() > 0), 1);
      if (q_c.size() > 0) begin
        e_c = q_c.pop_front();
        check_eq("c_data", 32'(data_c), 32'(e_c.data));
        check_eq("c_perr", 32'(perr_c), 32'(e_c.perr));
        check_eq("c_ferr", 32'(ferr_c), 32'(e_c.ferr));
      end
    end
  end

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  // Builds and drives one frame for instance 'which' (0: 8E1, 1: 8O1, 2: 7N2),
  // pushing the expected result first. bad_par inverts the correct parity bit,
  // bad_stop drives the last stop bit low.
  task automatic send_frame(input int which, input logic [8:0] d, input int bit_ns,
                            input bit bad_par, input bit bad_stop);
    int db, pm, sb;
    logic [8:0] dm;
    logic p;
    exp_t e;
    case (which)
      0:       begin db = 8; pm = 1; sb = 1; end
      1:       begin db = 8; pm = 2; sb = 1; end
      default: begin db = 7; pm = 0; sb = 2; end
    endcase
    dm = d & ((9'h1 << db) - 9'h1);
    p  = ^dm;
    if (pm == 2) p = ~p;
    if (bad_par) p = ~p;
    e.data = dm;
    e.perr = (pm != 0) && bad_par;
    e.ferr = bad_stop;
    case (which)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
    set_line(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < db; i++) begin
      set_line(which, dm[i]);
      #(bit_ns);
    end
    if (pm != 0) begin
      set_line(which, p);
      #(bit_ns);
    end
    for (int s = 0; s < sb; s++) begin
      set_line(which, !(bad_stop && (s == sb - 1)));
      #(bit_ns);
    end
    set_line(which, 1'b1);
  endtask

  task automatic wait_drain(input int which, input int max_ns, input string tag);
    int t;
    t = 0;
    while (qsize(which) > 0 && t < max_ns) begin
      #10;
      t += 10;
    end
    check_eq(tag, qsize(which), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d96;
    reset_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    #53;
    check_eq("rst_data_a",  32'(data_a),  0);
    check_eq("rst_valid_a", 32'(valid_a), 0);
    check_eq("rst_perr_a",  32'(perr_a),  0);
    check_eq("rst_ferr_a",  32'(ferr_a),  0);
    check_eq("rst_busy_a",  32'(busy_a),  0);
    check_eq("rst_busy_c",  32'(busy_c),  0);
    reset_n = 1'b1;
    #100;
    check_eq("idle_busy_a",  32'(busy_a),  0);
    check_eq("idle_valid_b", 32'(valid_b), 0);

    // Back-to-back even-parity frames.
    send_frame(0, 9'hA5, 160, 0, 0);
    send_frame(0, 9'h3C, 160, 0, 0);
    wait_drain(0, 2000, "drain_b2b");
    check_eq("b2b_gap", va_last - va_prev, 176);

    // Short glitch: FSM enters START then drops back, no frame.
    #300;
    rx_a = 1'b0;
    #40;
    check_eq("glitch_busy_hi", 32'(busy_a), 1);
    #10;
    rx_a = 1'b1;
    #300;
    check_eq("glitch_busy_lo", 32'(busy_a), 0);

    // Break: 20 bit times low gives one all-zero frame with a framing error,
    // then the receiver parks until the line returns high.
    begin
      exp_t e;
      e.data = 9'h000;
      e.perr = 1'b0;
      e.ferr = 1'b1;
      q_a.push_back(e);
    end
    rx_a = 1'b0;
    #3200;
    check_eq("brk_frame_seen", qsize(0), 0);
    check_eq("brk_busy_hold",  32'(busy_a), 1);
    rx_a = 1'b1;
    #100;
    check_eq("brk_busy_lo", 32'(busy_a), 0);
    #500;

    // Parity: even with wrong parity bit, odd with a correct parity bit of 0.
    send_frame(0, 9'h01, 160, 1, 0);
    wait_drain(0, 1000, "drain_perr_even");
    send_frame(1, 9'h01, 160, 0, 0);
    wait_drain(1, 1000, "drain_par_odd");

    // 7N2: second stop bit low, then a clean repeat.
    send_frame(2, 9'h55, 160, 0, 1);
    wait_drain(2, 1000, "drain_7n2_bad");
    #320;
    send_frame(2, 9'h55, 160, 0, 0);
    wait_drain(2, 1000, "drain_7n2_good");
    #300;

    // Reset in the middle of data bit 4; the partial frame must vanish.
    d96 = 8'h96;
    rx_a = 1'b0;
    #160;
    for (int i = 0; i < 4; i++) begin
      rx_a = d96[i];
      #160;
    end
    rx_a = d96[4];
    #80;
    check_eq("midrst_busy_before", 32'(busy_a), 1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_data",  32'(data_a),  0);
    check_eq("midrst_valid", 32'(valid_a), 0);
    check_eq("midrst_perr",  32'(perr_a),  0);
    check_eq("midrst_ferr",  32'(ferr_a),  0);
    check_eq("midrst_busy",  32'(busy_a),  0);
    rx_a = 1'b1;
    #199;
    reset_n = 1'b1;
    #200;
    send_frame(0, 9'h096, 160, 0, 0);
    wait_drain(0, 1000, "drain_after_rst");
    #300;

    // Baud skew: 128 random bytes at 15.7 clk/bit, 128 at 16.3, back-to-back.
    for (int i = 0; i < 256; i++) begin
      send_frame(0, 9'($urandom_range(0, 255)), (i < 128) ? 157 : 163, 0, 0);
    end
    wait_drain(0, 2000, "drain_skew");

    #1000;
    check_eq("end_q_a", qsize(0), 0);
    check_eq("end_q_b", qsize(1), 0);
    check_eq("end_q_c", qsize(2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
